// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : byte-stream command decoder issuing single 32-bit Wishbone cycles
// Revision : 1.0
// ============================================================================
module wb_cmd_master #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [16:0] wb_addr,
  output logic [31:0] wb_wdata,
  input  logic [31:0] wb_rdata,
  output logic [3:0]  wb_wstb,
  output logic        wb_we,
  output logic        wb_re,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic        wb_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RSP   = 3'd4
  } state_t;

  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);
  localparam logic [7:0]    c_op_wr    = 8'h01;
  localparam logic [7:0]    c_op_rd    = 8'h02;
  localparam logic [7:0]    c_st_ok    = 8'h00;
  localparam logic [7:0]    c_st_tmo   = 8'hEE;

  state_t        r_state;
  state_t        w_next;
  logic          r_run;
  logic          r_wr;
  logic [1:0]    r_cnt;
  logic [16:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [7:0]    r_status;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic          r_cyc;
  logic          r_we;
  logic          r_re;
  logic [3:0]    r_wstb;
  logic [16:0]   r_wb_addr;
  logic [31:0]   r_wb_wdata;

  logic          w_cmd_ready;
  logic          w_cmd_fire;
  logic          w_ack_hit;
  logic          w_tmo_hit;
  logic          w_rsp_valid;
  logic          w_rsp_fire;
  logic          w_rsp_last;
  logic          w_bus_start;
  logic [16:0]   w_addr_shift;
  logic [31:0]   w_wdata_shift;
  logic [7:0]    w_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_bus_start   = 1'b0;
    w_cmd_ready   = r_run && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_WDATA);
    w_cmd_fire    = w_cmd_ready && cmd_valid;
    w_ack_hit     = (r_state == S_BUS) && wb_ack;
    w_tmo_hit     = (r_state == S_BUS) && !wb_ack && (r_tmo == c_tmo_last);
    w_rsp_valid   = (r_state == S_RSP);
    w_rsp_fire    = w_rsp_valid && rsp_ready;
    // Only a successful read carries the four data bytes after the status.
    w_rsp_last    = r_wr || (r_status != c_st_ok) || (r_idx == 3'd4);
    w_addr_shift  = {r_addr[8:0], cmd_data};
    w_wdata_shift = {r_wdata[23:0], cmd_data};
    w_rsp_data    = 8'h00;
    if (w_rsp_valid) begin
      case (r_idx)
        3'd0:    w_rsp_data = r_status;
        3'd1:    w_rsp_data = r_rdata[31:24];
        3'd2:    w_rsp_data = r_rdata[23:16];
        3'd3:    w_rsp_data = r_rdata[15:8];
        3'd4:    w_rsp_data = r_rdata[7:0];
        default: w_rsp_data = 8'h00;
      endcase
    end
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire && (cmd_data == c_op_wr || cmd_data == c_op_rd)) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_cmd_fire && r_cnt == 2'd2) begin
          if (r_wr) begin
            w_next = S_WDATA;
          end else begin
            w_next      = S_BUS;
            w_bus_start = 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (w_cmd_fire && r_cnt == 2'd3) begin
          w_next      = S_BUS;
          w_bus_start = 1'b1;
        end
      end
      S_BUS: begin
        if (w_ack_hit || w_tmo_hit) w_next = S_RSP;
      end
      S_RSP: begin
        if (w_rsp_fire && w_rsp_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_wr       <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= 17'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_status   <= 8'h00;
      r_idx      <= 3'd0;
      r_tmo      <= '0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_wstb     <= 4'h0;
      r_wb_addr  <= 17'd0;
      r_wb_wdata <= 32'd0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_wr  <= (cmd_data == c_op_wr);
            r_cnt <= 2'd0;
          end
        end
        S_ADDR: begin
          if (w_cmd_fire) begin
            r_addr <= w_addr_shift;
            r_cnt  <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
          end
        end
        S_WDATA: begin
          if (w_cmd_fire) begin
            r_wdata <= w_wdata_shift;
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        S_BUS: begin
          r_idx <= 3'd0;
          if (wb_ack) begin
            if (!r_wr) r_rdata <= wb_rdata;
            r_status <= c_st_ok;
          end else if (w_tmo_hit) begin
            r_status <= c_st_tmo;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RSP: begin
          if (w_rsp_fire) r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase

      // The last command byte is still on cmd_data, so load bus outputs from the shifted value.
      if (w_bus_start) begin
        r_cyc      <= 1'b1;
        r_we       <= r_wr;
        r_re       <= !r_wr;
        r_wstb     <= r_wr ? 4'hF : 4'h0;
        r_wb_addr  <= (r_state == S_ADDR) ? w_addr_shift : r_addr;
        r_wb_wdata <= (r_state == S_WDATA) ? w_wdata_shift : r_wdata;
        r_tmo      <= '0;
      end else if (w_ack_hit || w_tmo_hit) begin
        r_cyc      <= 1'b0;
        r_we       <= 1'b0;
        r_re       <= 1'b0;
        r_wstb     <= 4'h0;
        r_wb_addr  <= 17'd0;
        r_wb_wdata <= 32'd0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = w_rsp_data;
  assign wb_addr   = r_wb_addr;
  assign wb_wdata  = r_wb_wdata;
  assign wb_wstb   = r_wstb;
  assign wb_we     = r_we;
  assign wb_re     = r_re;
  assign wb_cyc    = r_cyc;
  assign wb_stb    = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : self-checking bench for wb_cmd_master (vector table + random model)
// Revision : 1.0
// ============================================================================
module tb_wb_cmd_master;

  localparam int c_tmo = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [16:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic [3:0]  wb_wstb;
  logic        wb_we;
  logic        wb_re;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;

  wb_cmd_master #(.TIMEOUT(c_tmo), .TW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_wstb(wb_wstb),
    .wb_we(wb_we), .wb_re(wb_re), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    int          gap;
    int          e_ntx;
    logic [16:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_len;
    int          e_nrsp;
    logic [39:0] e_rsp;
  } vec_t;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [3:0]  wstb;
    int          len;
  } txn_t;

  txn_t       txn_q[$];
  logic [7:0] rsp_q[$];

  // Slave: acks ack_delay cycles after first seeing stb; negative means never.
  int          ack_delay;
  logic [31:0] slave_rdata;
  int          sl_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= 32'd0;
      sl_cnt   <= 0;
    end else begin
      wb_ack <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack) begin
        if (ack_delay >= 0 && sl_cnt >= ack_delay) begin
          wb_ack   <= 1'b1;
          wb_rdata <= slave_rdata;
          sl_cnt   <= 0;
        end else begin
          sl_cnt <= sl_cnt + 1;
        end
      end else begin
        sl_cnt <= 0;
      end
    end
  end

  int rdy_mode;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ~rsp_ready;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Bus monitor and response collector, both sampling mid-cycle.
  txn_t       cur;
  logic       in_cyc = 1'b0;
  logic       hold   = 1'b0;
  logic [7:0] hold_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_cyc = 1'b0;
      hold   = 1'b0;
    end else begin
      if (wb_cyc) begin
        check("stb_with_cyc", {wb_stb, wb_re}, {1'b1, !wb_we});
        if (!in_cyc) begin
          in_cyc    = 1'b1;
          cur.addr  = wb_addr;
          cur.wdata = wb_wdata;
          cur.we    = wb_we;
          cur.re    = wb_re;
          cur.wstb  = wb_wstb;
          cur.len   = 1;
        end else begin
          cur.len++;
          check("bus_stable", {wb_addr, wb_we, wb_re, wb_wstb, wb_wdata},
                {cur.addr, cur.we, cur.re, cur.wstb, cur.wdata});
        end
      end else begin
        check("bus_idle", {wb_stb, wb_we, wb_re}, 3'b000);
        if (in_cyc) begin
          txn_q.push_back(cur);
          in_cyc = 1'b0;
        end
      end
      if (hold) begin
        check("rsp_hold", {rsp_valid, rsp_data}, {1'b1, hold_data});
      end
      if (rsp_valid && rsp_ready) begin
        rsp_q.push_back(rsp_data);
        hold = 1'b0;
      end else if (rsp_valid) begin
        hold      = 1'b1;
        hold_data = rsp_data;
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Reference model: what one command frame must produce, from the protocol rules.
  function automatic vec_t mkvec(input logic [7:0] op, input logic [23:0] addr,
                                 input logic [31:0] wd, input int dly,
                                 input logic [31:0] rd, input int gap);
    vec_t v;
    logic ok;
    v.op = op; v.addr = addr; v.wdata = wd; v.ack_dly = dly; v.rdata = rd; v.gap = gap;
    v.e_ntx   = (op == 8'h01 || op == 8'h02) ? 1 : 0;
    v.e_addr  = addr[16:0];
    v.e_we    = (op == 8'h01);
    v.e_wdata = wd;
    ok        = (dly >= 0) && (dly + 2 <= c_tmo);
    v.e_len   = ok ? dly + 2 : c_tmo;
    if (v.e_ntx == 0) begin
      v.e_nrsp = 0; v.e_rsp = 40'h0;
    end else if (!ok) begin
      v.e_nrsp = 1; v.e_rsp = {8'hEE, 32'h0};
    end else if (v.e_we) begin
      v.e_nrsp = 1; v.e_rsp = 40'h0;
    end else begin
      v.e_nrsp = 5; v.e_rsp = {8'h00, rd};
    end
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic took;
    cmd_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    cmd_data  = b;
    cmd_valid = 1'b1;
    n    = 0;
    took = 1'b0;
    while (!took && n < 300) begin
      @(negedge clk);
      took = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", took, 1'b1);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int   n;
    txn_t t;
    ack_delay   = v.ack_dly;
    slave_rdata = v.rdata;
    send_byte(v.op, v.gap);
    if (v.op == 8'h01 || v.op == 8'h02) begin
      send_byte(v.addr[23:16], v.gap);
      send_byte(v.addr[15:8], v.gap);
      send_byte(v.addr[7:0], v.gap);
      if (v.op == 8'h01) begin
        for (int i = 3; i >= 0; i--) send_byte(v.wdata[8*i +: 8], v.gap);
      end
    end
    n = 0;
    while (rsp_q.size() < v.e_nrsp && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (12) begin @(posedge clk); #1; end
    check({tag, "_ntx"}, txn_q.size(), v.e_ntx);
    if (txn_q.size() > 0) begin
      t = txn_q.pop_front();
      check({tag, "_addr"}, t.addr, v.e_addr);
      check({tag, "_we_re_wstb"}, {t.we, t.re, t.wstb}, {v.e_we, !v.e_we, v.e_we ? 4'hF : 4'h0});
      if (v.e_we) check({tag, "_wdata"}, t.wdata, v.e_wdata);
      check({tag, "_cyc_len"}, t.len, v.e_len);
    end
    check({tag, "_nrsp"}, rsp_q.size(), v.e_nrsp);
    for (int i = 0; i < v.e_nrsp && i < rsp_q.size(); i++) begin
      check({tag, "_rsp_byte"}, rsp_q[i], v.e_rsp[39-8*i -: 8]);
    end
    txn_q.delete();
    rsp_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    vecs[0] = '{8'h01, 24'h004008, 32'hDEADBEEF, 0, 32'h0,        0, 1, 17'h04008, 1'b1, 32'hDEADBEEF, 2, 1, 40'h00_0000_0000};
    vecs[1] = '{8'h02, 24'h006010, 32'h0,        0, 32'h12345678, 0, 1, 17'h06010, 1'b0, 32'h0,        2, 5, 40'h00_1234_5678};
    vecs[2] = '{8'h02, 24'h000100, 32'h0,       -1, 32'h0BADF00D, 0, 1, 17'h00100, 1'b0, 32'h0,        8, 1, 40'hEE_0000_0000};
    vecs[3] = '{8'h01, 24'h001234, 32'hCAFEF00D, 2, 32'h0,        1, 1, 17'h01234, 1'b1, 32'hCAFEF00D, 4, 1, 40'h00_0000_0000};
    vecs[4] = '{8'h01, 24'hFFFFFC, 32'h00000001, 1, 32'h0,        3, 1, 17'h1FFFC, 1'b1, 32'h00000001, 3, 1, 40'h00_0000_0000};
    vecs[5] = '{8'h02, 24'h020000, 32'h0,        6, 32'hA5A55A5A, 0, 1, 17'h00000, 1'b0, 32'h0,        8, 5, 40'h00_A5A5_5A5A};
    vecs[6] = '{8'h02, 24'h01ABCD, 32'h0,        7, 32'h11223344, 0, 1, 17'h1ABCD, 1'b0, 32'h0,        8, 1, 40'hEE_0000_0000};
    vecs[7] = '{8'hFF, 24'h000000, 32'h0,        0, 32'h0,        0, 0, 17'h00000, 1'b0, 32'h0,        0, 0, 40'h00_0000_0000};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b1;
    rdy_mode = 0; ack_delay = 0; slave_rdata = 32'h0;
    #3;
    check("reset_outputs",
          {cmd_ready, rsp_valid, rsp_data, wb_cyc, wb_stb, wb_we, wb_re, wb_wstb, wb_addr, wb_wdata},
          64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Garbage opcode followed by a read under alternating backpressure.
    rdy_mode = 1;
    send_byte(8'h55, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("garbage_dropped", {32'(txn_q.size()), 32'(rsp_q.size())}, 64'h0);
    apply(mkvec(8'h02, 24'h006010, 32'h0, 0, 32'h12345678, 0), "bp_read");
    rdy_mode = 0;

    // Asynchronous reset while a read is waiting on an ack that never comes.
    ack_delay = -1;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    n = 0;
    while (!wb_cyc && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #3;
    check("cyc_before_reset", wb_cyc, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_cycle", {wb_cyc, wb_stb, cmd_ready, rsp_valid}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check("no_rsp_after_reset", {32'(txn_q.size()), 32'(rsp_q.size())}, 64'h0);
    apply(mkvec(8'h01, 24'h00ABCD, 32'h01020304, 0, 32'h0, 0), "post_reset_wr");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      int         r;
      int         dly;
      r = $urandom_range(0, 9);
      if (r < 4)      op = 8'h01;
      else if (r < 8) op = 8'h02;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h01 || op == 8'h02) op = 8'h00;
      end
      r   = $urandom_range(0, 9);
      dly = (r == 9) ? -1 : (r % 8);
      rdy_mode = $urandom_range(0, 2);
      v = mkvec(op, 24'($urandom), $urandom, dly, $urandom, $urandom_range(0, 2));
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
